// File: rtl/lpf_pkg.sv
// Shared types and constants for the biquad low-pass sequencer.
// The optional LPF_BIQUAD_ROUND_EN macro selects round-half-up instead of floor
// when the accumulator is scaled back to sample width.
package lpf_pkg;

   localparam int DW_DEF    = 18;
   localparam int CFRAC_DEF = 16;

   // Sequencer phases: one MAC per cycle, then wait out the wrapper pipeline.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_OUT   = 2'd3
   } lpf_state_e;

   // Wrapper opmode encodings (X mux / Z mux).
   localparam logic [1:0] OPX_ZERO = 2'b00;
   localparam logic [1:0] OPX_M    = 2'b01;
   localparam logic [1:0] OPZ_ZERO = 2'b00;
   localparam logic [1:0] OPZ_P    = 2'b10;

   // Last counter value in the MAC and DRAIN phases.
   localparam logic [2:0] MAC_LAST   = 3'd4;
   localparam logic [2:0] DRAIN_LAST = 3'd1;

   // Saturation limits for the default sample width.
   localparam logic signed [DW_DEF-1:0] SAT_MAX = 18'sh1FFFF;
   localparam logic signed [DW_DEF-1:0] SAT_MIN = 18'sh20000;

   // Largest / smallest value representable in dw signed bits, at accumulator width.
   function automatic logic signed [48:0] sat_hi(input int dw);
      return (49'sd1 <<< (dw - 1)) - 49'sd1;
   endfunction

   function automatic logic signed [48:0] sat_lo(input int dw);
      return -(49'sd1 <<< (dw - 1));
   endfunction

endpackage

// File: rtl/lpf_sat_round.sv
// Combinational scale-back of the 48-bit accumulator to a DW-bit sample.
// Arithmetic shift by CFRAC (floor), or round-half-up when LPF_BIQUAD_ROUND_EN
// is defined; the result is always saturated to the DW-bit signed range.
module lpf_sat_round
   import lpf_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int CFRAC = CFRAC_DEF
) (
   input  logic signed [47:0]   pout,
   output logic signed [DW-1:0] y,
   output logic                 sat
);

   localparam logic signed [48:0] Y_HI = sat_hi(DW);
   localparam logic signed [48:0] Y_LO = sat_lo(DW);

   // One extra bit keeps the rounding bias from wrapping at the top of the range.
   logic signed [48:0] biased;
   logic signed [48:0] shifted;

   // Shift, optionally round, then clamp to the output range.
   always_comb begin
      biased = {pout[47], pout};
`ifdef LPF_BIQUAD_ROUND_EN
      biased = biased + (49'sd1 <<< (CFRAC - 1));
`endif
      shifted = biased >>> CFRAC;
      sat     = 1'b0;
      y       = shifted[DW-1:0];
      if (shifted > Y_HI) begin
         y   = Y_HI[DW-1:0];
         sat = 1'b1;
      end else if (shifted < Y_LO) begin
         y   = Y_LO[DW-1:0];
         sat = 1'b1;
      end
   end

endmodule

// File: rtl/lpf_biquad_seq.sv
// Direct-form-I biquad sequencer feeding a 3-cycle MAC wrapper.
// Per sample: 5 MAC issues, 2 drain cycles, 1 output cycle (9-cycle cadence).
// Build option: LPF_BIQUAD_ROUND_EN enables round-half-up on the output scaling.
//
// Handshake: a sample is taken on any rising clk edge where sample_in_valid and
// sample_in_ready are both high; ready is high exactly while idle, and valid
// seen while not ready is dropped (no buffering). sample_out_valid is a
// one-cycle strobe with no backpressure.
module lpf_biquad_seq
   import lpf_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int CFRAC = CFRAC_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic signed [DW-1:0] sample_in,
   input  logic                 sample_in_valid,
   output logic                 sample_in_ready,
   input  logic signed [DW-1:0] coef_b0,
   input  logic signed [DW-1:0] coef_b1,
   input  logic signed [DW-1:0] coef_b2,
   input  logic signed [DW-1:0] coef_a1,
   input  logic signed [DW-1:0] coef_a2,
   input  logic                 hist_clr,
   output logic signed [DW-1:0] sample_out,
   output logic                 sample_out_valid,
   output logic                 sat_flag,
   output logic [1:0]           dsp_opmode_x,
   output logic [1:0]           dsp_opmode_z,
   output logic                 dsp_postadd_sub,
   output logic                 dsp_use_preadd,
   output logic                 dsp_cryin,
   output logic                 dsp_preadd_sub,
   output logic signed [DW-1:0] dsp_a,
   output logic signed [DW-1:0] dsp_b,
   input  logic signed [47:0]   dsp_pout
);

   lpf_state_e          state_q, state_d;
   logic [2:0]          k_q, k_d;
   logic signed [DW-1:0] x0_q, x0_d;
   logic signed [DW-1:0] b0_q, b0_d, b1_q, b1_d, b2_q, b2_d, a1_q, a1_d, a2_q, a2_d;
   logic signed [DW-1:0] x1_q, x1_d, x2_q, x2_d, y1_q, y1_d, y2_q, y2_d;
   logic                clr_pend_q, clr_pend_d;
   logic signed [DW-1:0] sample_out_q, sample_out_d;
   logic                sample_out_valid_q, sample_out_valid_d;
   logic                sat_q, sat_d;

   logic signed [DW-1:0] y_sat;
   logic                sat_now;
   logic                accept;

   lpf_sat_round #(.DW(DW), .CFRAC(CFRAC)) u_sat (
      .pout (dsp_pout),
      .y    (y_sat),
      .sat  (sat_now)
   );

   assign sample_in_ready  = (state_q == ST_IDLE);
   assign accept           = sample_in_valid & sample_in_ready;
   assign sample_out       = sample_out_q;
   assign sample_out_valid = sample_out_valid_q;
   assign sat_flag         = sat_q;
   assign dsp_use_preadd   = 1'b0;
   assign dsp_cryin        = 1'b0;
   assign dsp_preadd_sub   = 1'b0;

   // Next state, operand capture, history maintenance and output formation.
   always_comb begin
      state_d            = state_q;
      k_d                = k_q;
      x0_d               = x0_q;
      b0_d               = b0_q;
      b1_d               = b1_q;
      b2_d               = b2_q;
      a1_d               = a1_q;
      a2_d               = a2_q;
      x1_d               = x1_q;
      x2_d               = x2_q;
      y1_d               = y1_q;
      y2_d               = y2_q;
      clr_pend_d         = clr_pend_q;
      sample_out_d       = sample_out_q;
      sample_out_valid_d = 1'b0;
      sat_d              = sat_q;
      case (state_q)
         ST_IDLE: begin
            // Clear lands on the same edge as a simultaneous accept, so the
            // accepted sample sees zero history.
            if (hist_clr) begin
               x1_d = '0;
               x2_d = '0;
               y1_d = '0;
               y2_d = '0;
            end
            if (accept) begin
               state_d = ST_MAC;
               k_d     = '0;
               x0_d    = sample_in;
               b0_d    = coef_b0;
               b1_d    = coef_b1;
               b2_d    = coef_b2;
               a1_d    = coef_a1;
               a2_d    = coef_a2;
            end
         end
         ST_MAC: begin
            if (hist_clr) clr_pend_d = 1'b1;
            if (k_q == MAC_LAST) begin
               state_d = ST_DRAIN;
               k_d     = '0;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         ST_DRAIN: begin
            if (hist_clr) clr_pend_d = 1'b1;
            if (k_q == DRAIN_LAST) begin
               state_d = ST_OUT;
               k_d     = '0;
            end else begin
               k_d = k_q + 3'd1;
            end
         end
         ST_OUT: begin
            sample_out_d       = y_sat;
            sample_out_valid_d = 1'b1;
            sat_d              = sat_now;
            clr_pend_d         = 1'b0;
            state_d            = ST_IDLE;
            if (clr_pend_q || hist_clr) begin
               x1_d = '0;
               x2_d = '0;
               y1_d = '0;
               y2_d = '0;
            end else begin
               x2_d = x1_q;
               x1_d = x0_q;
               y2_d = y1_q;
               y1_d = y_sat;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Wrapper command for the current MAC step; idle otherwise.
   always_comb begin
      dsp_a           = '0;
      dsp_b           = '0;
      dsp_opmode_x    = OPX_ZERO;
      dsp_opmode_z    = OPZ_ZERO;
      dsp_postadd_sub = 1'b0;
      if (state_q == ST_MAC) begin
         dsp_opmode_x = OPX_M;
         dsp_opmode_z = OPZ_P;
         case (k_q)
            3'd0: begin
               dsp_a        = b0_q;
               dsp_b        = x0_q;
               dsp_opmode_z = OPZ_ZERO;
            end
            3'd1: begin
               dsp_a = b1_q;
               dsp_b = x1_q;
            end
            3'd2: begin
               dsp_a = b2_q;
               dsp_b = x2_q;
            end
            3'd3: begin
               dsp_a           = a1_q;
               dsp_b           = y1_q;
               dsp_postadd_sub = 1'b1;
            end
            3'd4: begin
               dsp_a           = a2_q;
               dsp_b           = y2_q;
               dsp_postadd_sub = 1'b1;
            end
            default: begin
               dsp_opmode_x = OPX_ZERO;
               dsp_opmode_z = OPZ_ZERO;
            end
         endcase
      end
   end

   // State register; reset aborts any sample in flight and zeroes history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q            <= ST_IDLE;
         k_q                <= '0;
         x0_q               <= '0;
         b0_q               <= '0;
         b1_q               <= '0;
         b2_q               <= '0;
         a1_q               <= '0;
         a2_q               <= '0;
         x1_q               <= '0;
         x2_q               <= '0;
         y1_q               <= '0;
         y2_q               <= '0;
         clr_pend_q         <= 1'b0;
         sample_out_q       <= '0;
         sample_out_valid_q <= 1'b0;
         sat_q              <= 1'b0;
      end else begin
         state_q            <= state_d;
         k_q                <= k_d;
         x0_q               <= x0_d;
         b0_q               <= b0_d;
         b1_q               <= b1_d;
         b2_q               <= b2_d;
         a1_q               <= a1_d;
         a2_q               <= a2_d;
         x1_q               <= x1_d;
         x2_q               <= x2_d;
         y1_q               <= y1_d;
         y2_q               <= y2_d;
         clr_pend_q         <= clr_pend_d;
         sample_out_q       <= sample_out_d;
         sample_out_valid_q <= sample_out_valid_d;
         sat_q              <= sat_d;
      end
   end

endmodule

// File: tb/tb_lpf_biquad_seq.sv
// Bench for lpf_biquad_seq: behavioural 3-cycle MAC wrapper, a reference biquad
// model that pushes {sat, y} into exp_q on every accepted sample, and a monitor
// that pops and compares on each sample_out_valid.
module tb_lpf_biquad_seq;

   localparam int DW    = 18;
   localparam int CFRAC = 16;

   logic                 clk = 1'b0;
   logic                 reset;
   logic signed [DW-1:0] sample_in;
   logic                 sample_in_valid;
   logic                 sample_in_ready;
   logic signed [DW-1:0] pb0, pb1, pb2, pa1, pa2;
   logic                 hist_clr;
   logic signed [DW-1:0] sample_out;
   logic                 sample_out_valid;
   logic                 sat_flag;
   logic [1:0]           dsp_opmode_x, dsp_opmode_z;
   logic                 dsp_postadd_sub, dsp_use_preadd, dsp_cryin, dsp_preadd_sub;
   logic signed [DW-1:0] dsp_a, dsp_b;
   logic signed [47:0]   dsp_pout;

   // Programmed coefficients and model history.
   logic signed [DW-1:0] cb0, cb1, cb2, ca1, ca2;
   logic signed [DW-1:0] hx1, hx2, hy1, hy2;

   logic [DW:0] exp_q[$];
   logic [DW:0] mon_e;
   int n_vec = 0;
   int n_bad = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   lpf_biquad_seq #(.DW(DW), .CFRAC(CFRAC)) dut (
      .clk              (clk),
      .reset            (reset),
      .sample_in        (sample_in),
      .sample_in_valid  (sample_in_valid),
      .sample_in_ready  (sample_in_ready),
      .coef_b0          (pb0),
      .coef_b1          (pb1),
      .coef_b2          (pb2),
      .coef_a1          (pa1),
      .coef_a2          (pa2),
      .hist_clr         (hist_clr),
      .sample_out       (sample_out),
      .sample_out_valid (sample_out_valid),
      .sat_flag         (sat_flag),
      .dsp_opmode_x     (dsp_opmode_x),
      .dsp_opmode_z     (dsp_opmode_z),
      .dsp_postadd_sub  (dsp_postadd_sub),
      .dsp_use_preadd   (dsp_use_preadd),
      .dsp_cryin        (dsp_cryin),
      .dsp_preadd_sub   (dsp_preadd_sub),
      .dsp_a            (dsp_a),
      .dsp_b            (dsp_b),
      .dsp_pout         (dsp_pout)
   );

   // ---------------- MAC wrapper model (issue -> pout in 3 cycles) ----------------
   typedef struct packed {
      logic signed [DW-1:0] a;
      logic signed [DW-1:0] b;
      logic [1:0]           ox;
      logic [1:0]           oz;
      logic                 sub;
   } dsp_op_t;

   dsp_op_t            iss, st1, st2;
   logic signed [47:0] p_acc;

   function automatic logic signed [47:0] dsp_next(input logic signed [47:0] p, input dsp_op_t op);
      logic signed [47:0] m, xv, zv;
      m  = 48'($signed(op.a)) * 48'($signed(op.b));
      xv = (op.ox == 2'b01) ? m : 48'sd0;
      zv = (op.oz == 2'b10) ? p : 48'sd0;
      return op.sub ? (zv - xv) : (zv + xv);
   endfunction

   always_comb begin
      iss.a   = dsp_a;
      iss.b   = dsp_b;
      iss.ox  = dsp_opmode_x;
      iss.oz  = dsp_opmode_z;
      iss.sub = dsp_postadd_sub;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         st1   <= '0;
         st2   <= '0;
         p_acc <= '0;
      end else begin
         st1   <= iss;
         st2   <= st1;
         p_acc <= dsp_next(p_acc, st2);
      end
   end

   assign dsp_pout = p_acc;

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference biquad: {sat, y} for input x using current model history.
   function automatic logic [DW:0] ref_out(input logic signed [DW-1:0] x);
      longint acc, v, hi, lo;
      acc = longint'(cb0) * longint'(x) + longint'(cb1) * longint'(hx1)
          + longint'(cb2) * longint'(hx2) - longint'(ca1) * longint'(hy1)
          - longint'(ca2) * longint'(hy2);
      v = acc;
`ifdef LPF_BIQUAD_ROUND_EN
      v = v + (longint'(1) <<< (CFRAC - 1));
`endif
      v  = v >>> CFRAC;
      hi = (longint'(1) <<< (DW - 1)) - 1;
      lo = -(longint'(1) <<< (DW - 1));
      if (v > hi)      ref_out = {1'b1, hi[DW-1:0]};
      else if (v < lo) ref_out = {1'b1, lo[DW-1:0]};
      else             ref_out = {1'b0, v[DW-1:0]};
   endfunction

   function automatic logic signed [DW-1:0] rnd_s(input int span);
      int r;
      r = int'($urandom_range(0, 2 * span)) - span;
      return DW'(r);
   endfunction

   // Scoreboard monitor: sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (!reset && sample_out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("y", $unsigned(sample_out), mon_e[DW-1:0]);
            chk("sat", sat_flag, mon_e[DW]);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic model_clear();
      hx1 = '0; hx2 = '0; hy1 = '0; hy2 = '0;
   endtask

   task automatic set_coefs(input logic signed [DW-1:0] b0, input logic signed [DW-1:0] b1,
                            input logic signed [DW-1:0] b2, input logic signed [DW-1:0] a1,
                            input logic signed [DW-1:0] a2);
      cb0 = b0; cb1 = b1; cb2 = b2; ca1 = a1; ca2 = a2;
      pb0 = b0; pb1 = b1; pb2 = b2; pa1 = a1; pa2 = a2;
   endtask

   task automatic clear_idle();
      hist_clr = 1'b1;
      @(posedge clk); #1;
      hist_clr = 1'b0;
      model_clear();
   endtask

   // Send one sample (entered #1 after an edge); returns in the cycle the output appears.
   task automatic send(input logic signed [DW-1:0] x, input bit clr_acc, input bit clr_busy);
      int cyc;
      logic [DW:0] e;
      cyc = 0;
      while (!sample_in_ready && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("ready_before_send", sample_in_ready, 64'd1);
      sample_in       = x;
      sample_in_valid = 1'b1;
      hist_clr        = clr_acc;
      if (clr_acc) model_clear();
      e = ref_out(x);
      exp_q.push_back(e);
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      hist_clr        = 1'b0;
      cyc = 1;
      while (!sample_out_valid && cyc < 30) begin
         if (cyc == 1) begin
            chk("k0_a", dsp_a, cb0);
            chk("k0_b", dsp_b, x);
            chk("k0_opx", dsp_opmode_x, 64'd1);
            chk("k0_opz", dsp_opmode_z, 64'd0);
         end
         if (cyc == 2) chk("busy_ready", sample_in_ready, 64'd0);
         if (cyc == 4) begin
            chk("k3_a", dsp_a, ca1);
            chk("k3_b", dsp_b, hy1);
            chk("k3_sub", dsp_postadd_sub, 64'd1);
            chk("k3_opz", dsp_opmode_z, 64'd2);
         end
         if (cyc == 6) begin
            chk("drain_opx", dsp_opmode_x, 64'd0);
            chk("drain_a", $unsigned(dsp_a), 64'd0);
         end
         hist_clr = clr_busy && (cyc == 3);
         // Junk valid and coefficient churn while busy must be ignored.
         sample_in_valid = 1'($urandom_range(0, 1));
         sample_in       = rnd_s(65535);
         pb0 = rnd_s(131071); pb1 = rnd_s(131071); pb2 = rnd_s(131071);
         pa1 = rnd_s(131071); pa2 = rnd_s(131071);
         @(posedge clk); #1;
         cyc++;
      end
      sample_in_valid = 1'b0;
      hist_clr        = 1'b0;
      pb0 = cb0; pb1 = cb1; pb2 = cb2; pa1 = ca1; pa2 = ca2;
      chk("latency", cyc, 64'd9);
      chk("ready_with_out", sample_in_ready, 64'd1);
      if (clr_busy) begin
         model_clear();
      end else begin
         hx2 = hx1; hx1 = x; hy2 = hy1; hy1 = e[DW-1:0];
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset           = 1'b1;
      sample_in       = '0;
      sample_in_valid = 1'b0;
      hist_clr        = 1'b0;
      set_coefs('0, '0, '0, '0, '0);
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", $unsigned(sample_out), 64'd0);
      chk("rst_valid", sample_out_valid, 64'd0);
      chk("rst_sat", sat_flag, 64'd0);
      chk("rst_dsp_a", $unsigned(dsp_a), 64'd0);
      chk("rst_dsp_b", $unsigned(dsp_b), 64'd0);
      chk("rst_opmodes", {dsp_opmode_x, dsp_opmode_z, dsp_postadd_sub}, 64'd0);
      chk("rst_ties", {dsp_use_preadd, dsp_cryin, dsp_preadd_sub}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("ready_after_rst", sample_in_ready, 64'd1);

      // Pass-through.
      set_coefs(18'sh10000, '0, '0, '0, '0);
      send(18'sd1000, 1'b0, 1'b0);

      // Recursion y = x + 0.5*y1.
      set_coefs(18'sh10000, '0, '0, 18'sh38000, '0);
      clear_idle();
      send(18'sd4096, 1'b0, 1'b0);
      send(18'sd0, 1'b0, 1'b0);
      send(18'sd0, 1'b0, 1'b0);

      // Clear together with accept: sample sees zero history.
      send(18'sd4096, 1'b1, 1'b0);
      // Clear while busy: output still emitted, history dropped afterwards.
      send(18'sd0, 1'b0, 1'b1);
      send(18'sd0, 1'b0, 1'b0);

      // Saturation, both rails.
      set_coefs(18'sh1FFFF, '0, '0, '0, '0);
      clear_idle();
      send(18'sh1FFFF, 1'b0, 1'b0);
      send(18'sh20000, 1'b0, 1'b0);

      // Rounding vs floor at a half-LSB.
      set_coefs(18'sh08000, '0, '0, '0, '0);
      clear_idle();
      send(18'sd3, 1'b0, 1'b0);
      send(-18'sd3, 1'b0, 1'b0);

      // Random coefficients, samples and clears.
      for (int i = 0; i < 16; i++) begin
         if (i % 4 == 0)
            set_coefs(rnd_s(65536), rnd_s(40000), rnd_s(30000), rnd_s(60000), rnd_s(30000));
         send(rnd_s(131071), ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
      end

      // Reset in cycle 4 of a sample with live history.
      set_coefs(18'sh10000, '0, '0, 18'sh38000, '0);
      send(18'sd4096, 1'b0, 1'b0);
      sample_in       = 18'sd777;
      sample_in_valid = 1'b1;
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("abort_valid", sample_out_valid, 64'd0);
      chk("abort_dsp_a", $unsigned(dsp_a), 64'd0);
      chk("abort_dsp_b", $unsigned(dsp_b), 64'd0);
      chk("abort_opmodes", {dsp_opmode_x, dsp_opmode_z, dsp_postadd_sub}, 64'd0);
      model_clear();
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      // First post-reset sample must behave as zero-history.
      send(18'sd1000, 1'b0, 1'b0);

      repeat (5) @(posedge clk);
      #1;
      chk("exp_q_empty", exp_q.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
